mem_axi_master: RTL

MEM_AXI_MASTER -- requirements
Module: mem_axi_master

---
 rtl/mem_axi_master_if.sv | 33 +++
 rtl/mem_axi_master.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_axi_master_if.sv
// mem_axi_master_if: AXI write/read channel bundle between mem_axi_master and its slave.
interface mem_axi_master_if #(
    parameter int DATA_LEN  = 32,
    parameter int STORB_LEN = 4,
    parameter int ADDR_LEN  = 32
);
    logic                 awvalid;
    logic                 awready;
    logic [ADDR_LEN-1:0]  waddr;
    logic                 wvalid;
    logic                 wready;
    logic [DATA_LEN-1:0]  wdata;
    logic [STORB_LEN-1:0] wstrob;
    logic                 bvalid;
    logic                 bready;
    logic [2:0]           bresp;
    logic                 arvalid;
    logic                 arready;
    logic [ADDR_LEN-1:0]  raddr;
    logic                 rvalid;
    logic                 rready;
    logic [DATA_LEN-1:0]  rdata;
    logic [2:0]           rresp;

    modport master (
        output awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/mem_axi_master.sv
// mem_axi_master: single-outstanding core request port bridged onto AXI write/read channels.
// Define MEM_AXI_MASTER_RESP_REG_EN to register the response one cycle after the b/r handshake.
module mem_axi_master #(
    parameter int DATA_LEN  = 32,
    parameter int STORB_LEN = 4,
    parameter int ADDR_LEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [ADDR_LEN-1:0]  req_addr,
    input  logic [DATA_LEN-1:0]  req_wdata,
    input  logic [STORB_LEN-1:0] req_wmask,
    output logic                 resp_valid,
    output logic [DATA_LEN-1:0]  resp_rdata,
    output logic                 resp_err,
    mem_axi_master_if.master     axi
);
    typedef enum logic [2:0] {IDLE, W_REQ, W_RESP, R_ADDR, R_DATA} state_e;
    state_e               state_q, state_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [DATA_LEN-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STORB_LEN-1:0] wmask_q, wmask_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                 arvalid_q, arvalid_d, rready_q, rready_d, err_q, err_d;
    logic                 b_hs, r_hs;

    assign b_hs        = axi.bvalid & bready_q;
    assign r_hs        = axi.rvalid & rready_q;
    assign req_ready   = state_q == IDLE;
    assign axi.awvalid = awvalid_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.waddr   = addr_q;
    assign axi.raddr   = addr_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrob  = wmask_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d    = req_addr;
                wdata_d   = req_wdata;
                wmask_d   = req_wmask;
                state_d   = req_wen ? W_REQ : R_ADDR;
                awvalid_d = req_wen;
                wvalid_d  = req_wen;
                arvalid_d = !req_wen;
            end
            // a dropped valid marks its channel as already handshaken
            W_REQ: begin
                awvalid_d = awvalid_q & !axi.awready;
                wvalid_d  = wvalid_q & !axi.wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = W_RESP;
                    bready_d = 1'b1;
                end
            end
            W_RESP: if (axi.bvalid) begin
                state_d  = IDLE;
                bready_d = 1'b0;
                rdata_d  = '0;
                err_d    = |axi.bresp;
            end
            R_ADDR: if (axi.arready) begin
                state_d   = R_DATA;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            R_DATA: if (axi.rvalid) begin
                state_d  = IDLE;
                rready_d = 1'b0;
                rdata_d  = axi.rdata;
                err_d    = |axi.rresp;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

`ifdef MEM_AXI_MASTER_RESP_REG_EN
    logic resp_valid_q, resp_valid_d;
    assign resp_valid_d = b_hs | r_hs;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resp_valid_q <= 1'b0;
        else        resp_valid_q <= resp_valid_d;
    end
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
`else
    // live response in the handshake cycle, captured copy held afterwards
    assign resp_valid = b_hs | r_hs;
    assign resp_rdata = r_hs ? axi.rdata : b_hs ? '0 : rdata_q;
    assign resp_err   = r_hs ? |axi.rresp : b_hs ? |axi.bresp : err_q;
`endif
endmodule
